cache_miss_handler: RTL and testbench
=====================================

// Module: cache_miss_handler
// PURPOSE
//  Upstream fill stage of the compressed BDI cache. Accepts a read miss, fetches the 16-word line from memory
//  critical-word-first, hands the 512-bit line to the compressor, then writes the cache entry.
//  Picks the victim way per set by round-robin and returns the missed word to the requester.
// PARAMETERS
//  TAG_FIELD        19       tag width
//  DATA_FIELD       256      compressed payload bits per cache entry
//  WORD_WIDTH       32       memory/CPU word width
//  LINE_WORDS       16       words per uncompressed line
//  SETS             128      sets; 8 ways, entry index10 = {way[2:0], set[6:0]}
// PORTS
//  clk                    in   1                       clock
//  rst_n                  in   1                       asynchronous active-low reset
//  miss_req_valid         in   1                       miss request
//  miss_req_ready         out  1                       high only in IDLE
//  miss_req_tag           in   TAG_FIELD               missed tag
//  miss_req_index         in   7                       missed set
//  miss_req_word_addr     in   4                       missed word in line
//  mem_req_valid          out  1                       memory burst request
//  mem_req_ready          in   1                       memory accepts request
//  mem_req_addr           out  32                      {tag,index,word_addr,2'b00}
//  mem_rsp_valid          in   1                       one beat per cycle when high
//  mem_rsp_data           in   WORD_WIDTH              beat data
//  comp_valid             out  1                       line presented to compressor
//  comp_line              out  LINE_WORDS*WORD_WIDTH   assembled line, word k at [32k+:32]
//  comp_done              in   1                       compressor result valid (1-cycle pulse)
//  comp_fits              in   1                       whole line fits in DATA_FIELD
//  comp_data              in   DATA_FIELD              compressed payload
//  cache_write_data       out  2+TAG_FIELD+DATA_FIELD  {valid_hi,valid_lo,tag,payload}
//  cache_write_index      out  10                      {victim_way,set}
//  cache_write_on_demand  out  1                       1-cycle write strobe
//  miss_resp_valid        out  1                       1-cycle pulse, missed word returned
//  miss_resp_word         out  WORD_WIDTH              missed word
// BEHAVIOUR
//  - Reset: all outputs 0; FSM to IDLE; every victim pointer 0. Reset mid-miss aborts it: no write, no response.
//  - FSM: IDLE -(req valid)-> REQ -(mem_req_ready)-> FILL -(16th beat)-> COMP -(comp_done)-> WRITE -> DONE -> IDLE.
//  - IDLE: request captured on miss_req_valid&&miss_req_ready. REQ: mem_req_valid held until ready; address stable.
//  - FILL: beat b (0..15) writes word (word_addr+b) mod 16 (4-bit wrap). Beats seen outside FILL are ignored.
//  - COMP: comp_valid held high with a stable comp_line until comp_done. comp_data/comp_fits sampled on comp_done.
//  - WRITE: cache_write_on_demand pulses 1 cycle. Index = {victim_ptr[set], set}.
//    fits=1: valid bits 2'b11 and payload = comp_data.
//    fits=0: store the uncompressed half containing the missed word.
//      word_addr[3]=0 -> valid 2'b01, words 0-7; word_addr[3]=1 -> valid 2'b10, words 8-15.
//  - The victim pointer for the set increments (mod 8) in WRITE, wraps 7->0; other sets are unchanged.
//  - DONE: miss_resp_valid pulses with the missed word (unless the forward feature already returned it); then IDLE.
//  - Minimum latency from acceptance to write strobe is 1 REQ cycle + 16 beats + compressor latency + 1 cycle.
// CONFIGURATION
//  CACHE_MISS_CRIT_WORD_FWD_EN defined:
//    - miss_resp_valid pulses in the cycle after beat 0 (the critical word), with that word.
//    - DONE emits no second response.
//  Undefined: response only in DONE, after the cache write.
// STRUCTURE
//  cache_pkg:
//    - width localparams (TAG_FIELD, DATA_FIELD, LINE_WORDS, WAYS=8);
//    - typedef enum miss_state_t {IDLE,REQ,FILL,COMP,WRITE,DONE};
//    - packed struct cache_entry_t {valid_hi, valid_lo, tag, payload}.
//  Sub-module victim_rr_table: 128x3-bit pointer array.
//    - Ports: read set (combinational); inc strobe + set; async reset to 0.
// TESTING
//  1. Miss tag=0x1234, idx=5, word=3:
//     -> mem_req_addr={0x1234,7'd5,4'd3,2'b00}; beats 0..15 land in words 3..15,0..2.
//  2. Same miss with comp_fits=1, comp_data=P -> one strobe, index=10'd5, data={2'b11,0x1234,P}, set 5 pointer -> 1.
//  3. comp_fits=0, word_addr=4'd9 -> valid 2'b10, payload = words 8-15; miss_resp_word = word 9.
//  4. Nine misses to set 5 -> way sequence 0..7 then 0; set 6 pointer stays 0.
//  5. rst_n low during FILL beat 7 -> no strobe or response; after release, new request accepted.
//  6. FWD_EN defined, word=12: resp pulse the cycle after beat 0 with mem word 12, none in DONE.
//     Undefined: pulse one cycle after the strobe.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared widths, FSM state encoding and cache entry layout for the BDI cache fill path.
package cache_pkg;

  localparam int TAG_FIELD     = 19;
  localparam int DATA_FIELD    = 256;
  localparam int WORD_WIDTH    = 32;
  localparam int LINE_WORDS    = 16;
  localparam int SETS          = 128;
  localparam int WAYS          = 8;
  localparam int SET_BITS      = $clog2(SETS);
  localparam int WAY_BITS      = $clog2(WAYS);
  localparam int WORD_IDX_BITS = $clog2(LINE_WORDS);
  localparam int LINE_BITS     = LINE_WORDS * WORD_WIDTH;
  localparam int ENTRY_BITS    = 2 + TAG_FIELD + DATA_FIELD;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FILL,
    COMP,
    WRITE,
    DONE
  } miss_state_t;

  typedef struct packed {
    logic                  valid_hi;
    logic                  valid_lo;
    logic [TAG_FIELD-1:0]  tag;
    logic [DATA_FIELD-1:0] payload;
  } cache_entry_t;

  // Critical-word-first burst: beat b lands in word (crit + b) mod LINE_WORDS.
  function automatic logic [WORD_IDX_BITS-1:0] fill_slot(
    input logic [WORD_IDX_BITS-1:0] crit,
    input logic [WORD_IDX_BITS-1:0] beat
  );
    return crit + beat;
  endfunction

endpackage

// File: rtl/cache_miss_handler_victim_rr_table.sv
// Per-set round-robin victim pointers: combinational read, single increment port.
module victim_rr_table
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SET_BITS-1:0] rd_set,
  output logic [WAY_BITS-1:0] rd_way,
  input  logic                inc,
  input  logic [SET_BITS-1:0] inc_set
);

  logic [WAY_BITS-1:0] ptr [SETS];

  // Pointer wraps 7 -> 0 naturally through the 3-bit add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '{default: '0};
    end else if (inc) begin
      ptr[inc_set] <= ptr[inc_set] + 1'b1;
    end
  end

  assign rd_way = ptr[rd_set];

endmodule

// File: rtl/cache_miss_handler.sv
// Read-miss fill engine: burst fetch, compress, victim write, missed-word return.
// Define CACHE_MISS_CRIT_WORD_FWD_EN to return the critical word right after beat 0.
module cache_miss_handler
  import cache_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     miss_req_valid,
  output logic                     miss_req_ready,
  input  logic [TAG_FIELD-1:0]     miss_req_tag,
  input  logic [SET_BITS-1:0]      miss_req_index,
  input  logic [WORD_IDX_BITS-1:0] miss_req_word_addr,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [31:0]              mem_req_addr,
  input  logic                     mem_rsp_valid,
  input  logic [WORD_WIDTH-1:0]    mem_rsp_data,
  output logic                     comp_valid,
  output logic [LINE_BITS-1:0]     comp_line,
  input  logic                     comp_done,
  input  logic                     comp_fits,
  input  logic [DATA_FIELD-1:0]    comp_data,
  output logic [ENTRY_BITS-1:0]    cache_write_data,
  output logic [9:0]               cache_write_index,
  output logic                     cache_write_on_demand,
  output logic                     miss_resp_valid,
  output logic [WORD_WIDTH-1:0]    miss_resp_word
);

  miss_state_t state, state_next;

  logic [TAG_FIELD-1:0]                     req_tag_q;
  logic [SET_BITS-1:0]                      req_set_q;
  logic [WORD_IDX_BITS-1:0]                 req_word_q;
  logic [WORD_IDX_BITS-1:0]                 beat_q;
  logic [LINE_WORDS-1:0][WORD_WIDTH-1:0]    line_q;
  logic                                     comp_fits_q;
  logic [DATA_FIELD-1:0]                    comp_data_q;
  logic                                     resp_valid_q;
  logic [WORD_WIDTH-1:0]                    resp_word_q;
  logic [WAY_BITS-1:0]                      victim_way;
  logic                                     victim_inc;
  cache_entry_t                             write_entry;

  victim_rr_table u_victim (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_set  (req_set_q),
    .rd_way  (victim_way),
    .inc     (victim_inc),
    .inc_set (req_set_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next            = state;
    miss_req_ready        = 1'b0;
    mem_req_valid         = 1'b0;
    comp_valid            = 1'b0;
    cache_write_on_demand = 1'b0;
    victim_inc            = 1'b0;
    case (state)
      IDLE: begin
        miss_req_ready = 1'b1;
        if (miss_req_valid) state_next = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_next = FILL;
      end
      FILL: begin
        if (mem_rsp_valid && (beat_q == WORD_IDX_BITS'(LINE_WORDS - 1))) state_next = COMP;
      end
      COMP: begin
        comp_valid = 1'b1;
        if (comp_done) state_next = WRITE;
      end
      WRITE: begin
        cache_write_on_demand = 1'b1;
        victim_inc            = 1'b1;
        state_next            = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request context, line assembly and compressor result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_tag_q   <= '0;
      req_set_q   <= '0;
      req_word_q  <= '0;
      beat_q      <= '0;
      line_q      <= '0;
      comp_fits_q <= 1'b0;
      comp_data_q <= '0;
    end else begin
      if (state == IDLE && miss_req_valid) begin
        req_tag_q  <= miss_req_tag;
        req_set_q  <= miss_req_index;
        req_word_q <= miss_req_word_addr;
      end
      if (state == REQ) begin
        beat_q <= '0;
      end else if (state == FILL && mem_rsp_valid) begin
        line_q[fill_slot(req_word_q, beat_q)] <= mem_rsp_data;
        beat_q                                <= beat_q + 1'b1;
      end
      if (state == COMP && comp_done) begin
        comp_fits_q <= comp_fits;
        comp_data_q <= comp_data;
      end
    end
  end

`ifdef CACHE_MISS_CRIT_WORD_FWD_EN
  // Beat 0 always carries the missed word, so forward it straight from the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_word_q  <= '0;
    end else begin
      resp_valid_q <= (state == FILL) && mem_rsp_valid && (beat_q == '0);
      if ((state == FILL) && mem_rsp_valid && (beat_q == '0)) resp_word_q <= mem_rsp_data;
    end
  end
`else
  // Registered out of WRITE so the pulse lands in DONE, after the cache write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_word_q  <= '0;
    end else begin
      resp_valid_q <= (state == WRITE);
      if (state == WRITE) resp_word_q <= line_q[req_word_q];
    end
  end
`endif

  // An uncompressible line keeps only the half holding the missed word.
  always_comb begin
    write_entry       = '0;
    cache_write_index = '0;
    if (state == WRITE) begin
      write_entry.valid_hi = comp_fits_q | req_word_q[WORD_IDX_BITS-1];
      write_entry.valid_lo = comp_fits_q | ~req_word_q[WORD_IDX_BITS-1];
      write_entry.tag      = req_tag_q;
      if (comp_fits_q)                      write_entry.payload = comp_data_q;
      else if (req_word_q[WORD_IDX_BITS-1]) write_entry.payload = line_q[LINE_WORDS-1:LINE_WORDS/2];
      else                                  write_entry.payload = line_q[LINE_WORDS/2-1:0];
      cache_write_index = {victim_way, req_set_q};
    end
  end

  assign cache_write_data = write_entry;
  assign mem_req_addr     = {req_tag_q, req_set_q, req_word_q, 2'b00};
  assign comp_line        = line_q;
  assign miss_resp_valid  = resp_valid_q;
  assign miss_resp_word   = resp_word_q;

endmodule

// File: tb/tb_cache_miss_handler.sv
// Directed scoreboard bench for cache_miss_handler; expectations queued at stimulus time.
module tb_cache_miss_handler;
  import cache_pkg::*;

  logic                     clk;
  logic                     rst_n;
  logic                     miss_req_valid;
  logic                     miss_req_ready;
  logic [TAG_FIELD-1:0]     miss_req_tag;
  logic [SET_BITS-1:0]      miss_req_index;
  logic [WORD_IDX_BITS-1:0] miss_req_word_addr;
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic [31:0]              mem_req_addr;
  logic                     mem_rsp_valid;
  logic [WORD_WIDTH-1:0]    mem_rsp_data;
  logic                     comp_valid;
  logic [LINE_BITS-1:0]     comp_line;
  logic                     comp_done;
  logic                     comp_fits;
  logic [DATA_FIELD-1:0]    comp_data;
  logic [ENTRY_BITS-1:0]    cache_write_data;
  logic [9:0]               cache_write_index;
  logic                     cache_write_on_demand;
  logic                     miss_resp_valid;
  logic [WORD_WIDTH-1:0]    miss_resp_word;

  cache_miss_handler dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .miss_req_valid        (miss_req_valid),
    .miss_req_ready        (miss_req_ready),
    .miss_req_tag          (miss_req_tag),
    .miss_req_index        (miss_req_index),
    .miss_req_word_addr    (miss_req_word_addr),
    .mem_req_valid         (mem_req_valid),
    .mem_req_ready         (mem_req_ready),
    .mem_req_addr          (mem_req_addr),
    .mem_rsp_valid         (mem_rsp_valid),
    .mem_rsp_data          (mem_rsp_data),
    .comp_valid            (comp_valid),
    .comp_line             (comp_line),
    .comp_done             (comp_done),
    .comp_fits             (comp_fits),
    .comp_data             (comp_data),
    .cache_write_data      (cache_write_data),
    .cache_write_index     (cache_write_index),
    .cache_write_on_demand (cache_write_on_demand),
    .miss_resp_valid       (miss_resp_valid),
    .miss_resp_word        (miss_resp_word)
  );

  typedef struct {
    logic [9:0]            index;
    logic [ENTRY_BITS-1:0] data;
  } exp_write_t;

  exp_write_t  exp_write_q[$];
  logic [31:0] exp_resp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int beat0_cyc = 0;
  int done_cyc = 0;
  int strobe_cyc = 0;
  int n_writes = 0;
  int n_resps = 0;
  int ptr_model[SETS];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memWord(input int seed, input logic [6:0] idx,
                                          input logic [18:0] tag, input int w);
    return {seed[7:0], 1'b0, idx, tag[11:0], w[3:0]};
  endfunction

  // Scoreboard side: every write strobe and response pops the oldest expectation.
  always @(negedge clk) begin
    exp_write_t e;
    logic [31:0] r;
    if (rst_n) begin
      if (cache_write_on_demand) begin
        checkOutput("write_expected", 512'(exp_write_q.size() != 0), 512'd1);
        if (exp_write_q.size() != 0) begin
          e = exp_write_q.pop_front();
          checkOutput("write_index", 512'(cache_write_index), 512'(e.index));
          checkOutput("write_data", 512'(cache_write_data), 512'(e.data));
          checkOutput("write_latency", 512'(cyc), 512'(done_cyc + 1));
        end
        strobe_cyc = cyc;
        n_writes++;
      end
      if (miss_resp_valid) begin
        checkOutput("resp_expected", 512'(exp_resp_q.size() != 0), 512'd1);
        if (exp_resp_q.size() != 0) begin
          r = exp_resp_q.pop_front();
          checkOutput("resp_word", 512'(miss_resp_word), 512'(r));
`ifdef CACHE_MISS_CRIT_WORD_FWD_EN
          checkOutput("resp_timing_fwd", 512'(cyc), 512'(beat0_cyc + 1));
`else
          checkOutput("resp_timing_done", 512'(cyc), 512'(strobe_cyc + 1));
`endif
        end
        n_resps++;
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ctrl"}, 512'({mem_req_valid, comp_valid, cache_write_on_demand, miss_resp_valid}), 512'd0);
    checkOutput({tag, "_data"}, 512'({cache_write_index, cache_write_data}), 512'd0);
    checkOutput({tag, "_line"}, 512'(comp_line), 512'd0);
  endtask

  task automatic applyStimulus(input logic [18:0] tag, input logic [6:0] idx, input logic [3:0] word,
                               input logic fits, input int seed, input int abort_beat, input bit bubble);
    logic [31:0]           words[16];
    logic [511:0]          line;
    logic [DATA_FIELD-1:0] pdata;
    exp_write_t            e;
    for (int w = 0; w < 16; w++) begin
      words[w] = memWord(seed, idx, tag, w);
      line[32*w +: 32] = words[w];
    end
    pdata = {8{32'hC0DE_0000 | 32'(seed)}};
    if (abort_beat < 0) begin
      e.index = {3'(ptr_model[idx]), idx};
      if (fits)         e.data = {2'b11, tag, pdata};
      else if (word[3]) e.data = {2'b10, tag, line[511:256]};
      else              e.data = {2'b01, tag, line[255:0]};
      exp_write_q.push_back(e);
      ptr_model[idx] = (ptr_model[idx] + 1) % WAYS;
    end
`ifdef CACHE_MISS_CRIT_WORD_FWD_EN
    exp_resp_q.push_back(words[word]);
`else
    if (abort_beat < 0) exp_resp_q.push_back(words[word]);
`endif

    @(negedge clk);
    checkOutput("req_ready_idle", 512'(miss_req_ready), 512'd1);
    miss_req_valid = 1'b1;
    miss_req_tag = tag;
    miss_req_index = idx;
    miss_req_word_addr = word;
    @(negedge clk);
    miss_req_valid = 1'b0;
    miss_req_tag = '1;
    miss_req_word_addr = ~word;
    checkOutput("req_ready_busy", 512'(miss_req_ready), 512'd0);
    for (int i = 0; i < 10 && !mem_req_valid; i++) @(negedge clk);
    checkOutput("mem_req_addr", 512'({mem_req_valid, mem_req_addr}), 512'({1'b1, tag, idx, word, 2'b00}));
    repeat (2) @(negedge clk);
    checkOutput("mem_req_hold", 512'({mem_req_valid, mem_req_addr}), 512'({1'b1, tag, idx, word, 2'b00}));
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    checkOutput("mem_req_drop", 512'(mem_req_valid), 512'd0);

    for (int b = 0; b < 16; b++) begin
      if (bubble && b == 5) begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data = 32'hFFFF_FFFF;
        @(negedge clk);
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_data = words[4'(int'(word) + b)];
      if (b == 0) beat0_cyc = cyc;
      if (b == abort_beat) rst_n = 1'b0;
      @(negedge clk);
      if (b == abort_beat) break;
    end
    mem_rsp_valid = 1'b0;

    if (abort_beat >= 0) begin
      checkResetOutputs("abort_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int s = 0; s < SETS; s++) ptr_model[s] = 0;
      repeat (5) @(negedge clk);
      checkOutput("abort_queues", 512'(exp_write_q.size() + exp_resp_q.size()), 512'd0);
      return;
    end

    for (int i = 0; i < 5 && !comp_valid; i++) @(negedge clk);
    checkOutput("comp_line", 512'({comp_valid, comp_line}), {1'b1, line});
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    checkOutput("comp_line_stable", 512'({comp_valid, comp_line}), {1'b1, line});
    comp_done = 1'b1;
    comp_fits = fits;
    comp_data = pdata;
    done_cyc = cyc;
    @(negedge clk);
    comp_done = 1'b0;
    comp_fits = ~fits;
    comp_data = ~pdata;
    for (int i = 0; i < 6 && (exp_write_q.size() + exp_resp_q.size()) != 0; i++) @(negedge clk);
    checkOutput("drain", 512'(exp_write_q.size() + exp_resp_q.size()), 512'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    miss_req_valid = 1'b0;
    miss_req_tag = '0;
    miss_req_index = '0;
    miss_req_word_addr = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    comp_done = 1'b0;
    comp_fits = 1'b0;
    comp_data = '0;
    for (int s = 0; s < SETS; s++) ptr_model[s] = 0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_ready", 512'(miss_req_ready), 512'd1);

    $display("[TB] miss tag=0x1234 set 5 word 3, line fits");
    applyStimulus(19'h1234, 7'd5, 4'd3, 1'b1, 1, -1, 1'b1);
    $display("[TB] uncompressible miss, word 9, set 7");
    applyStimulus(19'h0ABCD, 7'd7, 4'd9, 1'b0, 2, -1, 1'b0);
    $display("[TB] word 12 on set 5 takes way 1");
    applyStimulus(19'h7FFFF, 7'd5, 4'd12, 1'b0, 3, -1, 1'b0);
    $display("[TB] reset during fill beat 7");
    applyStimulus(19'h00042, 7'd5, 4'd0, 1'b1, 4, 7, 1'b0);
    $display("[TB] nine misses to set 5 after reset");
    for (int n = 0; n < 9; n++)
      applyStimulus(19'(20'h100 + n), 7'd5, 4'((n * 5) % 16), n[0], 10 + n, -1, 1'b0);
    $display("[TB] set 6 still starts at way 0");
    applyStimulus(19'h2AAAA, 7'd6, 4'd15, 1'b0, 30, -1, 1'b0);

    checkOutput("writes_total", 512'(n_writes), 512'd13);
`ifdef CACHE_MISS_CRIT_WORD_FWD_EN
    checkOutput("resps_total", 512'(n_resps), 512'd14);
`else
    checkOutput("resps_total", 512'(n_resps), 512'd13);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
